// File: rtl/rng_scheduler.sv
// rng_scheduler: shares one random-word generator among NUM_REQ requesters.
// A round-robin arbiter picks a requester, the FSM fetches a word from the
// generator, captures it into rand_out and pulses the winner's grant bit.
// A user seed switch reseeds the generator between transactions, and a
// missing generator acknowledge aborts the fetch and raises a sticky error.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting; seed_start has priority, else arbitrate requests
// SEED     | lfsr_start held high while the seed switch stays on
// FETCH    | one-cycle fetch pulse, timeout counter cleared
// WAIT_ACK | waiting for lfsr_ack; abort after ACK_TIMEOUT cycles
// DELIVER  | one-cycle grant to the latched winner, advance rr_ptr
module rng_scheduler #(
    parameter int NUM_REQ     = 4,
    parameter int WIDTH       = 28,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               seed_start,
    input  logic [NUM_REQ-1:0] req,
    output logic               lfsr_start,
    output logic               lfsr_fetch,
    input  logic               lfsr_ack,
    input  logic [WIDTH-1:0]   lfsr_data,
    output logic [NUM_REQ-1:0] grant,
    output logic [WIDTH-1:0]   rand_out,
    output logic               busy,
    output logic               timeout_err
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

    // The counter runs 0..ACK_TIMEOUT-1, so the last value marks the
    // ACK_TIMEOUT-th cycle spent waiting.
    localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(ACK_TIMEOUT - 1);
    localparam logic [IDX_W:0]   NUM_REQ_EXT = (IDX_W + 1)'(NUM_REQ);

    typedef enum logic [2:0] {
        IDLE,
        SEED,
        FETCH,
        WAIT_ACK,
        DELIVER
    } state_t;

    state_t             state;
    state_t             state_next;

    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   winner;
    logic [CNT_W-1:0]   ack_cnt;

    logic [NUM_REQ-1:0] req_rot;
    logic               req_found;
    logic [IDX_W:0]     pick_sum;
    logic [IDX_W-1:0]   pick_idx;
    logic [IDX_W:0]     ptr_sum;
    logic [IDX_W-1:0]   rr_next;
    logic               ack_expired;

    // Round-robin pick: rotate req so rr_ptr lands at bit 0, take the
    // lowest set bit, then map the offset back to a requester index.
    always_comb begin
        req_rot   = NUM_REQ'({req, req} >> rr_ptr);
        req_found = 1'b0;
        pick_sum  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!req_found && req_rot[i]) begin
                req_found = 1'b1;
                pick_sum  = {1'b0, rr_ptr} + (IDX_W + 1)'(i);
            end
        end
        if (pick_sum >= NUM_REQ_EXT) begin
            pick_sum = pick_sum - NUM_REQ_EXT;
        end
        pick_idx = pick_sum[IDX_W-1:0];
    end

    // Pointer for the next search: one past the requester just served.
    always_comb begin
        ptr_sum = {1'b0, winner} + (IDX_W + 1)'(1);
        if (ptr_sum >= NUM_REQ_EXT) begin
            ptr_sum = '0;
        end
        rr_next = ptr_sum[IDX_W-1:0];
    end

    // An ack on the final waiting cycle still wins over the timeout.
    always_comb begin
        ack_expired = (state == WAIT_ACK) && !lfsr_ack && (ack_cnt == CNT_LAST);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and state-derived outputs. Outputs are forced low
    // while reset is asserted so nothing leaks out of an aborted transaction.
    always_comb begin
        state_next = state;
        lfsr_start = 1'b0;
        lfsr_fetch = 1'b0;
        busy       = 1'b0;
        grant      = '0;

        case (state)
            IDLE: begin
                if (seed_start) begin
                    state_next = SEED;
                end else if (req_found) begin
                    state_next = FETCH;
                end
            end
            SEED: begin
                lfsr_start = 1'b1;
                if (!seed_start) begin
                    state_next = IDLE;
                end
            end
            FETCH: begin
                lfsr_fetch = 1'b1;
                state_next = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (lfsr_ack) begin
                    state_next = DELIVER;
                end else if (ack_expired) begin
                    state_next = IDLE;
                end
            end
            DELIVER: begin
                grant      = NUM_REQ'(1) << winner;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        busy = (state != IDLE);

        if (reset) begin
            lfsr_start = 1'b0;
            lfsr_fetch = 1'b0;
            busy       = 1'b0;
            grant      = '0;
        end
    end

    // Transaction datapath: winner latch, ack timer, word capture, pointer
    // advance and the sticky timeout flag. A timeout leaves rr_ptr alone so
    // the same requester is retried.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr      <= '0;
            winner      <= '0;
            ack_cnt     <= '0;
            rand_out    <= '0;
            timeout_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!seed_start && req_found) begin
                        winner <= pick_idx;
                    end
                end
                FETCH: begin
                    ack_cnt <= '0;
                end
                WAIT_ACK: begin
                    if (lfsr_ack) begin
                        rand_out <= lfsr_data;
                    end else if (ack_expired) begin
                        timeout_err <= 1'b1;
                    end else begin
                        ack_cnt <= ack_cnt + CNT_W'(1);
                    end
                end
                DELIVER: begin
                    rr_ptr <= rr_next;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rng_scheduler.sv
// Directed bench for rng_scheduler. A small generator model answers each
// fetch one cycle later; every task starts and ends at a falling edge with
// the DUT in IDLE and checks outputs at falling edges.
module tb_rng_scheduler;

    localparam int NUM_REQ     = 4;
    localparam int WIDTH       = 28;
    localparam int ACK_TIMEOUT = 15;

    logic               clk = 1'b0;
    logic               reset;
    logic               seed_start;
    logic [NUM_REQ-1:0] req;
    logic               lfsr_start;
    logic               lfsr_fetch;
    logic               lfsr_ack;
    logic [WIDTH-1:0]   lfsr_data;
    logic [NUM_REQ-1:0] grant;
    logic [WIDTH-1:0]   rand_out;
    logic               busy;
    logic               timeout_err;

    logic ack_en;
    logic force_ack;
    logic fetch_d;

    int vectors = 0;
    int errors  = 0;

    rng_scheduler #(
        .NUM_REQ    (NUM_REQ),
        .WIDTH      (WIDTH),
        .ACK_TIMEOUT(ACK_TIMEOUT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .seed_start (seed_start),
        .req        (req),
        .lfsr_start (lfsr_start),
        .lfsr_fetch (lfsr_fetch),
        .lfsr_ack   (lfsr_ack),
        .lfsr_data  (lfsr_data),
        .grant      (grant),
        .rand_out   (rand_out),
        .busy       (busy),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // Generator model: ack is high in the cycle after a fetch cycle.
    initial begin
        lfsr_ack = 1'b0;
        fetch_d  = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            lfsr_ack = force_ack | (ack_en & fetch_d);
            fetch_d  = lfsr_fetch;
        end
    end

    task automatic test_reset();
        reset = 1'b1; req = 4'b1111; seed_start = 1'b1;
        repeat (3) @(negedge clk);
        vectors++; if (grant !== 4'b0000) begin errors++; $display("FAIL rst_grant: got %b want %b", grant, 4'b0000); end
        vectors++; if (lfsr_fetch !== 1'b0) begin errors++; $display("FAIL rst_fetch: got %b want 0", lfsr_fetch); end
        vectors++; if (lfsr_start !== 1'b0) begin errors++; $display("FAIL rst_start: got %b want 0", lfsr_start); end
        vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
        vectors++; if (rand_out !== 28'h0) begin errors++; $display("FAIL rst_rand: got %h want 0", rand_out); end
        vectors++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL rst_terr: got %b want 0", timeout_err); end
        reset = 1'b0; req = 4'b0000; seed_start = 1'b0;
        @(negedge clk);
        vectors++; if (grant !== 4'b0000) begin errors++; $display("FAIL post_rst_grant: got %b want 0000", grant); end
        vectors++; if (lfsr_fetch !== 1'b0) begin errors++; $display("FAIL post_rst_fetch: got %b want 0", lfsr_fetch); end
        vectors++; if (lfsr_start !== 1'b0) begin errors++; $display("FAIL post_rst_start: got %b want 0", lfsr_start); end
        vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL post_rst_busy: got %b want 0", busy); end
    endtask

    // rr_ptr=0 on entry; leaves rr_ptr=1.
    task automatic test_round_robin();
        logic [3:0] order [5];
        logic [3:0] exp_g;
        logic       exp_f;
        order[0] = 4'b0001; order[1] = 4'b0010; order[2] = 4'b0100;
        order[3] = 4'b1000; order[4] = 4'b0001;
        lfsr_data = 28'h0000111;
        req = 4'b1111;
        for (int k = 1; k <= 19; k++) begin
            @(negedge clk);
            exp_g = ((k % 4) == 3) ? order[k / 4] : 4'b0000;
            exp_f = ((k % 4) == 1);
            vectors++; if (grant !== exp_g) begin errors++; $display("FAIL rr_grant k=%0d: got %b want %b", k, grant, exp_g); end
            vectors++; if (lfsr_fetch !== exp_f) begin errors++; $display("FAIL rr_fetch k=%0d: got %b want %b", k, lfsr_fetch, exp_f); end
            vectors++; if (lfsr_start !== 1'b0) begin errors++; $display("FAIL rr_start k=%0d: got %b want 0", k, lfsr_start); end
            if (k == 19) req = 4'b0000;
        end
        @(negedge clk);
        vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL rr_idle_busy: got %b want 0", busy); end
    endtask

    // Seed switch on for 10 cycles with a pending request; leaves rr_ptr=1.
    task automatic test_seed();
        seed_start = 1'b1; req = 4'b0001;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            vectors++; if (lfsr_start !== 1'b1) begin errors++; $display("FAIL seed_start k=%0d: got %b want 1", k, lfsr_start); end
            vectors++; if (lfsr_fetch !== 1'b0) begin errors++; $display("FAIL seed_fetch k=%0d: got %b want 0", k, lfsr_fetch); end
            vectors++; if (grant !== 4'b0000) begin errors++; $display("FAIL seed_grant k=%0d: got %b want 0000", k, grant); end
            if (k == 10) seed_start = 1'b0;
        end
        @(negedge clk);
        vectors++; if (lfsr_start !== 1'b0) begin errors++; $display("FAIL seed_end_start: got %b want 0", lfsr_start); end
        vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL seed_end_busy: got %b want 0", busy); end
        @(negedge clk);
        vectors++; if (lfsr_fetch !== 1'b1) begin errors++; $display("FAIL seed_then_fetch: got %b want 1", lfsr_fetch); end
        req = 4'b0000;
        @(negedge clk);
        vectors++; if (grant !== 4'b0000) begin errors++; $display("FAIL seed_early_grant: got %b want 0000", grant); end
        @(negedge clk);
        vectors++; if (grant !== 4'b0001) begin errors++; $display("FAIL seed_then_grant: got %b want 0001", grant); end
        @(negedge clk);
        vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL seed_final_busy: got %b want 0", busy); end
    endtask

    // Seed request during WAIT_ACK waits for the grant; leaves rr_ptr=0.
    task automatic test_seed_during_wait();
        lfsr_data = 28'h5A5A5A5;
        req = 4'b1000;
        @(negedge clk);
        vectors++; if (lfsr_fetch !== 1'b1) begin errors++; $display("FAIL sdw_fetch: got %b want 1", lfsr_fetch); end
        req = 4'b0000;
        @(negedge clk);
        vectors++; if (busy !== 1'b1) begin errors++; $display("FAIL sdw_wait_busy: got %b want 1", busy); end
        seed_start = 1'b1;
        @(negedge clk);
        vectors++; if (grant !== 4'b1000) begin errors++; $display("FAIL sdw_grant: got %b want 1000", grant); end
        vectors++; if (rand_out !== 28'h5A5A5A5) begin errors++; $display("FAIL sdw_rand: got %h want 5a5a5a5", rand_out); end
        vectors++; if (lfsr_start !== 1'b0) begin errors++; $display("FAIL sdw_deliver_start: got %b want 0", lfsr_start); end
        @(negedge clk);
        vectors++; if (lfsr_start !== 1'b0) begin errors++; $display("FAIL sdw_idle_start: got %b want 0", lfsr_start); end
        vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL sdw_idle_busy: got %b want 0", busy); end
        @(negedge clk);
        vectors++; if (lfsr_start !== 1'b1) begin errors++; $display("FAIL sdw_seed_start: got %b want 1", lfsr_start); end
        vectors++; if (lfsr_fetch !== 1'b0) begin errors++; $display("FAIL sdw_seed_fetch: got %b want 0", lfsr_fetch); end
        seed_start = 1'b0;
        @(negedge clk);
        vectors++; if (lfsr_start !== 1'b0) begin errors++; $display("FAIL sdw_end_start: got %b want 0", lfsr_start); end
        vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL sdw_end_busy: got %b want 0", busy); end
    endtask

    // Generator silent: abort after 15 WAIT_ACK cycles, then retry; leaves rr_ptr=3.
    task automatic test_timeout();
        ack_en = 1'b0; req = 4'b0100; lfsr_data = 28'h1234567;
        @(negedge clk);
        vectors++; if (lfsr_fetch !== 1'b1) begin errors++; $display("FAIL to_fetch: got %b want 1", lfsr_fetch); end
        for (int k = 2; k <= 16; k++) begin
            @(negedge clk);
            vectors++; if (busy !== 1'b1) begin errors++; $display("FAIL to_wait_busy k=%0d: got %b want 1", k, busy); end
            vectors++; if (grant !== 4'b0000) begin errors++; $display("FAIL to_wait_grant k=%0d: got %b want 0000", k, grant); end
            vectors++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL to_early_err k=%0d: got %b want 0", k, timeout_err); end
        end
        @(negedge clk);
        vectors++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL to_err: got %b want 1", timeout_err); end
        vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL to_idle_busy: got %b want 0", busy); end
        vectors++; if (grant !== 4'b0000) begin errors++; $display("FAIL to_idle_grant: got %b want 0000", grant); end
        vectors++; if (rand_out !== 28'h5A5A5A5) begin errors++; $display("FAIL to_rand_held: got %h want 5a5a5a5", rand_out); end
        ack_en = 1'b1;
        @(negedge clk);
        vectors++; if (lfsr_fetch !== 1'b1) begin errors++; $display("FAIL to_retry_fetch: got %b want 1", lfsr_fetch); end
        req = 4'b0000;
        @(negedge clk);
        @(negedge clk);
        vectors++; if (grant !== 4'b0100) begin errors++; $display("FAIL to_retry_grant: got %b want 0100", grant); end
        vectors++; if (rand_out !== 28'h1234567) begin errors++; $display("FAIL to_retry_rand: got %h want 1234567", rand_out); end
        vectors++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL to_sticky: got %b want 1", timeout_err); end
        @(negedge clk);
        vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL to_end_busy: got %b want 0", busy); end
    endtask

    // Ack arriving while IDLE must not capture data.
    task automatic test_stray_ack();
        force_ack = 1'b1; lfsr_data = 28'hFFFFFFF;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL stray_busy k=%0d: got %b want 0", k, busy); end
            vectors++; if (rand_out !== 28'h1234567) begin errors++; $display("FAIL stray_rand k=%0d: got %h want 1234567", k, rand_out); end
        end
        force_ack = 1'b0;
        @(negedge clk);
        vectors++; if (rand_out !== 28'h1234567) begin errors++; $display("FAIL stray_rand_end: got %h want 1234567", rand_out); end
    endtask

    // Single request with latency check and early req drop; rr_ptr 3 -> 2 -> 3.
    task automatic test_basic();
        req = 4'b0010; lfsr_data = 28'h0ABCDEF;
        vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_t_busy: got %b want 0", busy); end
        @(negedge clk);
        vectors++; if (lfsr_fetch !== 1'b1) begin errors++; $display("FAIL basic_fetch: got %b want 1", lfsr_fetch); end
        vectors++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy1: got %b want 1", busy); end
        req = 4'b0000;
        @(negedge clk);
        vectors++; if (lfsr_fetch !== 1'b0) begin errors++; $display("FAIL basic_fetch_once: got %b want 0", lfsr_fetch); end
        vectors++; if (grant !== 4'b0000) begin errors++; $display("FAIL basic_grant_early: got %b want 0000", grant); end
        @(negedge clk);
        vectors++; if (grant !== 4'b0010) begin errors++; $display("FAIL basic_grant: got %b want 0010", grant); end
        vectors++; if (rand_out !== 28'h0ABCDEF) begin errors++; $display("FAIL basic_rand: got %h want 0abcdef", rand_out); end
        vectors++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy3: got %b want 1", busy); end
        @(negedge clk);
        vectors++; if (grant !== 4'b0000) begin errors++; $display("FAIL basic_grant_once: got %b want 0000", grant); end
        vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy4: got %b want 0", busy); end
        req = 4'b0101;
        @(negedge clk);
        req = 4'b0000;
        @(negedge clk);
        @(negedge clk);
        vectors++; if (grant !== 4'b0100) begin errors++; $display("FAIL basic_ptr2_grant: got %b want 0100", grant); end
        @(negedge clk);
        vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_ptr2_busy: got %b want 0", busy); end
    endtask

    // Reset in WAIT_ACK: no grant, outputs cleared, pointer back to 0.
    task automatic test_reset_mid();
        req = 4'b0100; lfsr_data = 28'h7777777;
        @(negedge clk);
        vectors++; if (lfsr_fetch !== 1'b1) begin errors++; $display("FAIL rm_fetch: got %b want 1", lfsr_fetch); end
        req = 4'b0000;
        @(negedge clk);
        reset = 1'b1;
        #1;
        vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL rm_during_busy: got %b want 0", busy); end
        vectors++; if (grant !== 4'b0000) begin errors++; $display("FAIL rm_during_grant: got %b want 0000", grant); end
        @(negedge clk);
        vectors++; if (grant !== 4'b0000) begin errors++; $display("FAIL rm_after_grant: got %b want 0000", grant); end
        vectors++; if (rand_out !== 28'h0) begin errors++; $display("FAIL rm_rand: got %h want 0", rand_out); end
        vectors++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL rm_terr: got %b want 0", timeout_err); end
        reset = 1'b0;
        @(negedge clk);
        vectors++; if (grant !== 4'b0000) begin errors++; $display("FAIL rm_post_grant: got %b want 0000", grant); end
        vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL rm_post_busy: got %b want 0", busy); end
        vectors++; if (lfsr_fetch !== 1'b0) begin errors++; $display("FAIL rm_post_fetch: got %b want 0", lfsr_fetch); end
        req = 4'b1001; lfsr_data = 28'h0C0FFEE;
        @(negedge clk);
        vectors++; if (lfsr_fetch !== 1'b1) begin errors++; $display("FAIL rm_new_fetch: got %b want 1", lfsr_fetch); end
        req = 4'b0000;
        @(negedge clk);
        vectors++; if (grant !== 4'b0000) begin errors++; $display("FAIL rm_new_early: got %b want 0000", grant); end
        @(negedge clk);
        vectors++; if (grant !== 4'b0001) begin errors++; $display("FAIL rm_new_grant: got %b want 0001", grant); end
        vectors++; if (rand_out !== 28'h0C0FFEE) begin errors++; $display("FAIL rm_new_rand: got %h want 0c0ffee", rand_out); end
        @(negedge clk);
        vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL rm_end_busy: got %b want 0", busy); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got time limit reached want bench completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset      = 1'b1;
        seed_start = 1'b0;
        req        = 4'b0000;
        lfsr_data  = '0;
        ack_en     = 1'b1;
        force_ack  = 1'b0;

        test_reset();
        test_round_robin();
        test_seed();
        test_seed_during_wait();
        test_timeout();
        test_stray_ack();
        test_basic();
        test_reset_mid();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
